// File: rtl/usb_uart_pkg.sv
// Shared types and constants for the USB-to-UART bridge.
package usb_uart_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  localparam int unsigned PRESCALE_MUL = 8;
  localparam int unsigned HALF_BIT     = 4;

endpackage

// File: rtl/bridge_fifo.sv
// First-word-fall-through FIFO with extra-MSB pointers; one instance per direction.
module bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  import usb_uart_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A pop frees a slot in the same cycle, so push is accepted while full if popping.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/usb_uart_bridge.sv
// AXI-Stream <-> UART bridge with TX/RX FIFOs and optional RTS/CTS flow control.
// Define UART_FLOW_CTRL_EN to honour cts_n and drive rts_n from the RX fill level.
module usb_uart_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int RTS_THRESH = FIFO_DEPTH - 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   prescale,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          txd,
  input  logic                          rxd,
  output logic                          rts_n,
  input  logic                          cts_n,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun_err
);
  import usb_uart_pkg::*;

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = 19;

  function automatic logic [CW-1:0] scale(input logic [15:0] p, input int unsigned mul);
    logic [15:0] sat;
    sat = (p == 16'd0) ? 16'd1 : p;
    return CW'(sat) * CW'(mul);
  endfunction

  logic                  tx_full, tx_empty, tx_pop;
  logic [DATA_WIDTH-1:0] tx_dout;
  logic                  rx_full, rx_empty, rx_push, rx_pop;
  logic                  cts_ok, rts_q;

  assign s_axis_tready = ~tx_full & ~rst;
  assign m_axis_tvalid = ~rx_empty;
  assign rx_pop        = m_axis_tvalid & m_axis_tready;
  assign rts_n         = rts_q;

  bridge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(s_axis_tvalid & s_axis_tready), .din(s_axis_tdata),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_d;

  bridge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(m_axis_tdata), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

`ifdef UART_FLOW_CTRL_EN
  logic cts_p0, cts_p1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_p0 <= 1'b1;
      cts_p1 <= 1'b1;
    end else begin
      cts_p0 <= cts_n;
      cts_p1 <= cts_p0;
    end
  end
  assign cts_ok = ~cts_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rts_q <= 1'b1;
    else     rts_q <= (rx_level >= LW'(RTS_THRESH));
  end
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign cts_ok     = 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rts_q <= 1'b1;
    else     rts_q <= 1'b0;
  end
`endif

  // ---- TX stage: FIFO word -> serial frame ----
  tx_state_t             tx_state, tx_next;
  logic [CW-1:0]         tx_cnt, tx_cnt_d, tx_len, tx_len_d;
  logic [3:0]            tx_bit, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_d;
  logic                  txd_q, txd_d;

  always_comb begin
    tx_next  = tx_state;
    tx_cnt_d = tx_cnt;
    tx_len_d = tx_len;
    tx_bit_d = tx_bit;
    tx_sh_d  = tx_sh;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty && cts_ok) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_dout;
          tx_len_d = scale(prescale, PRESCALE_MUL);
          tx_cnt_d = scale(prescale, PRESCALE_MUL) - 1'b1;
          txd_d    = 1'b0;
          tx_next  = TX_START;
        end
      end
      TX_START, TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = tx_len - 1'b1;
          if (tx_state == TX_DATA && tx_bit == 4'(DATA_WIDTH - 1)) begin
            txd_d   = 1'b1;
            tx_next = TX_STOP;
          end else begin
            tx_bit_d = (tx_state == TX_START) ? 4'd0 : tx_bit + 4'd1;
            txd_d    = tx_sh[0];
            tx_sh_d  = tx_sh >> 1;
            tx_next  = TX_DATA;
          end
        end else begin
          tx_cnt_d = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) tx_next = TX_IDLE;
        else              tx_cnt_d = tx_cnt - 1'b1;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_len <= tx_len_d;
    tx_bit <= tx_bit_d;
    tx_sh  <= tx_sh_d;
  end

  assign txd = txd_q;

  // ---- RX stage: synchronised line -> FIFO word ----
  logic                  rxd_p0, rxd_p1, rxd_p2;
  rx_state_t             rx_state, rx_next;
  logic [CW-1:0]         rx_cnt, rx_cnt_d, rx_len, rx_len_d;
  logic [3:0]            rx_bit, rx_bit_d;
  logic                  fe_d, ov_d, fe_q, ov_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_cnt_d = rx_cnt;
    rx_len_d = rx_len;
    rx_bit_d = rx_bit;
    rx_sh_d  = rx_sh;
    rx_push  = 1'b0;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxd_p2 && !rxd_p1) begin
          rx_len_d = scale(prescale, PRESCALE_MUL);
          rx_cnt_d = scale(prescale, HALF_BIT) - 1'b1;
          rx_next  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - 1'b1;
        end else if (rxd_p1) begin
          rx_next = RX_IDLE;
        end else begin
          rx_cnt_d = rx_len - 1'b1;
          rx_bit_d = 4'd0;
          rx_next  = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_sh_d  = {rxd_p1, rx_sh[DATA_WIDTH-1:1]};
          rx_cnt_d = rx_len - 1'b1;
          rx_bit_d = rx_bit + 4'd1;
          if (rx_bit == 4'(DATA_WIDTH - 1)) rx_next = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_d = rx_cnt - 1'b1;
        end else if (rxd_p1) begin
          if (rx_full && !rx_pop) ov_d = 1'b1;
          else                    rx_push = 1'b1;
          rx_next = RX_IDLE;
        end else begin
          fe_d    = 1'b1;
          rx_next = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rxd_p1) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      fe_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_d;
      fe_q     <= fe_d;
      ov_q     <= ov_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_len <= rx_len_d;
    rx_bit <= rx_bit_d;
    rx_sh  <= rx_sh_d;
  end

  assign frame_err   = fe_q;
  assign overrun_err = ov_q;

endmodule

// File: tb/tb_usb_uart_bridge.sv
// Self-checking bench for usb_uart_bridge: line-level UART model plus FIFO queues.
module tb_usb_uart_bridge;

  logic        clk, rst;
  logic [15:0] prescale;
  logic [7:0]  s_axis_tdata, m_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic        txd, rxd, rts_n, cts_n, frame_err, overrun_err;
  logic [4:0]  tx_level, rx_level;

  int checks, errors, cyc, fe_cnt, ov_cnt, mon_len;
  logic [7:0] tx_seen[$];
  logic       tx_stop[$];
  int         tx_start[$];

  usb_uart_bridge #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .prescale(prescale),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .txd(txd), .rxd(rxd), .rts_n(rts_n), .cts_n(cts_n),
    .tx_level(tx_level), .rx_level(rx_level), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1)   fe_cnt <= fe_cnt + 1;
    if (overrun_err === 1'b1) ov_cnt <= ov_cnt + 1;
  end

  // Line receiver on txd: samples each bit at its middle using mon_len cycles per bit.
  initial begin
    forever begin
      logic [7:0] b;
      int len, t0;
      @(negedge txd);
      t0  = cyc;
      len = mon_len;
      repeat (len / 2) @(negedge clk);
      if (txd === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (len) @(negedge clk);
          b[i] = txd;
        end
        repeat (len) @(negedge clk);
        tx_seen.push_back(b);
        tx_stop.push_back(txd);
        tx_start.push_back(t0);
      end
    end
  end

  function automatic int bit_len(input int p);
    return ((p == 0) ? 1 : p) * 8;
  endfunction

  task automatic clear_mon();
    tx_seen.delete();
    tx_stop.delete();
    tx_start.delete();
  endtask

  task automatic push_word(input logic [7:0] d);
    int n;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    n = 0;
    while (s_axis_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL push_timeout tready stuck at %b want 1", s_axis_tready);
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_seen.size() < n; i++) @(negedge clk);
    if (tx_seen.size() < n) begin
      checks++; errors++;
      $display("FAIL tx_frame_timeout got %0d frames want %0d", tx_seen.size(), n);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopv, input int len);
    rxd = 1'b0;
    repeat (len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (len) @(negedge clk);
    end
    rxd = stopv;
    repeat (len) @(negedge clk);
    rxd = 1'b1;
    repeat (len) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", txd); end
    checks++; if (rts_n !== 1'b1) begin errors++; $display("FAIL rst_rts_n got %b want 1", rts_n); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
    checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL rst_levels got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin errors++; $display("FAIL rst_errs got %b%b want 00", frame_err, overrun_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rts_n !== 1'b0) begin errors++; $display("FAIL rel_rts_n got %b want 0", rts_n); end
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got %b want 1", s_axis_tready); end
  endtask

  task automatic test_tx_pattern();
    logic [7:0] v;
    logic expb;
    int n, bad;
    v = 8'hA5;
    prescale = 16'h0035;
    mon_len = 424;
    clear_mon();
    push_word(v);
    n = 0;
    while (txd !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 10; k++) begin
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : v[k-1];
      bad = 0;
      for (int c = 0; c < 424; c++) begin
        if (txd !== expb) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL tx_a5_bit%0d got %0d wrong cycles want 0 (level %b)", k, bad, expb); end
    end
    wait_tx(1, 1000);
    checks++; if (tx_seen.size() < 1 || tx_seen[0] !== v) begin errors++; $display("FAIL tx_a5_decode got %p want a5", tx_seen); end
  endtask

  task automatic test_tx_random();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int p;
    for (int r = 0; r < 3; r++) begin
      p = (r == 0) ? 0 : int'($urandom_range(1, 3));
      prescale = 16'(p);
      mon_len = bit_len(p);
      clear_mon();
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
        d = 8'($urandom);
        exp_q.push_back(d);
        push_word(d);
      end
      wait_tx(5, 5 * 12 * mon_len + 200);
      for (int i = 0; i < 5 && i < tx_seen.size(); i++) begin
        checks++; if (tx_seen[i] !== exp_q[i]) begin errors++; $display("FAIL tx_rand p%0d w%0d got %h want %h", p, i, tx_seen[i], exp_q[i]); end
        checks++; if (tx_stop[i] !== 1'b1) begin errors++; $display("FAIL tx_stop p%0d w%0d got %b want 1", p, i, tx_stop[i]); end
      end
    end
  endtask

  task automatic test_rx_pattern();
    prescale = 16'd1;
    m_axis_tready = 1'b0;
    send_frame(8'h3C, 1'b1, 8);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rx_3c_tvalid got %b want 1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h3C) begin errors++; $display("FAIL rx_3c_tdata got %h want 3c", m_axis_tdata); end
    checks++; if (rx_level !== 5'd1) begin errors++; $display("FAIL rx_3c_level got %0d want 1", rx_level); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    checks++; if (m_axis_tvalid !== 1'b0 || rx_level !== 5'd0) begin errors++; $display("FAIL rx_pop got valid %b level %0d want 0 0", m_axis_tvalid, rx_level); end
  endtask

  task automatic test_rx_random();
    logic [7:0] d;
    int p;
    for (int i = 0; i < 6; i++) begin
      p = int'($urandom_range(0, 3));
      prescale = 16'(p);
      d = 8'($urandom);
      send_frame(d, 1'b1, bit_len(p));
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d) begin errors++; $display("FAIL rx_rand p%0d got %b/%h want 1/%h", p, m_axis_tvalid, m_axis_tdata, d); end
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    int fe0;
    prescale = 16'd2;
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (rx_level !== 5'd0 || fe_cnt != fe0) begin errors++; $display("FAIL glitch got level %0d ferr %0d want 0 0", rx_level, fe_cnt - fe0); end
    send_frame(8'($urandom), 1'b0, 16);
    repeat (4) @(negedge clk);
    checks++; if (fe_cnt != fe0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d pulses want 1", fe_cnt - fe0); end
    checks++; if (rx_level !== 5'd0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ferr_nopush got level %0d want 0", rx_level); end
    d = 8'($urandom);
    send_frame(d, 1'b1, 16);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || rx_level !== 5'd1) begin errors++; $display("FAIL ferr_recover got %b/%h/%0d want 1/%h/1", m_axis_tvalid, m_axis_tdata, rx_level, d); end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic exp_rts;
    int ov0, lvl;
    prescale = 16'd1;
    m_axis_tready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 1; k <= 17; k++) begin
      d = 8'($urandom);
      send_frame(d, 1'b1, 8);
      if (exp_q.size() < 16) exp_q.push_back(d);
      lvl = exp_q.size();
`ifdef UART_FLOW_CTRL_EN
      exp_rts = (lvl >= 12);
`else
      exp_rts = 1'b0;
`endif
      checks++; if (rx_level !== 5'(lvl)) begin errors++; $display("FAIL ovr_level f%0d got %0d want %0d", k, rx_level, lvl); end
      checks++; if (rts_n !== exp_rts) begin errors++; $display("FAIL ovr_rts f%0d got %b want %b", k, rts_n, exp_rts); end
    end
    checks++; if (ov_cnt != ov0 + 1) begin errors++; $display("FAIL ovr_pulse got %0d pulses want 1", ov_cnt - ov0); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_q[i]) begin errors++; $display("FAIL ovr_drain w%0d got %b/%h want 1/%h", i, m_axis_tvalid, m_axis_tdata, exp_q[i]); end
      m_axis_tready = 1'b1;
      @(negedge clk);
      m_axis_tready = 1'b0;
    end
    @(negedge clk);
    checks++; if (rx_level !== 5'd0 || rts_n !== 1'b0) begin errors++; $display("FAIL ovr_empty got level %0d rts %b want 0 0", rx_level, rts_n); end
  endtask

  task automatic test_cts();
    logic [7:0] exp_q[$];
    int bad;
    prescale = 16'd1;
    mon_len = 8;
    clear_mon();
    cts_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'($urandom));
      push_word(exp_q[i]);
    end
`ifdef UART_FLOW_CTRL_EN
    bad = 0;
    repeat (100) begin
      if (txd !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL cts_hold got %0d low cycles want 0", bad); end
    checks++; if (tx_level !== 5'd3) begin errors++; $display("FAIL cts_level got %0d want 3", tx_level); end
    cts_n = 1'b0;
`endif
    wait_tx(3, 1000);
    repeat (200) @(negedge clk);
    checks++; if (tx_seen.size() != 3) begin errors++; $display("FAIL cts_count got %0d frames want 3", tx_seen.size()); end
    for (int i = 0; i < 3 && i < tx_seen.size(); i++) begin
      checks++; if (tx_seen[i] !== exp_q[i]) begin errors++; $display("FAIL cts_data w%0d got %h want %h", i, tx_seen[i], exp_q[i]); end
      if (i > 0) begin
        checks++; if (tx_start[i] - tx_start[i-1] > 82) begin errors++; $display("FAIL cts_gap w%0d got %0d cycles want <=82", i, tx_start[i] - tx_start[i-1]); end
      end
    end
    cts_n = 1'b0;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int n, bad;
    prescale = 16'd1;
    mon_len = 8;
    m_axis_tready = 1'b0;
    send_frame(8'($urandom), 1'b1, 8);
    for (int i = 0; i < 3; i++) push_word(8'($urandom));
    n = 0;
    while (txd !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b want 1", txd); end
    checks++; if (tx_level !== 5'd0 || rx_level !== 5'd0) begin errors++; $display("FAIL mid_rst_levels got %0d/%0d want 0/0", tx_level, rx_level); end
    checks++; if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_rst_handshake got %b/%b want 0/0", m_axis_tvalid, s_axis_tready); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_rst_idle got %0d low cycles want 0", bad); end
    clear_mon();
    d = 8'($urandom);
    push_word(d);
    wait_tx(1, 400);
    checks++; if (tx_seen.size() < 1 || tx_seen[0] !== d) begin errors++; $display("FAIL mid_rst_next got %p want %h", tx_seen, d); end
  endtask

  initial begin
    rst = 1'b1;
    prescale = 16'd1;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    rxd = 1'b1;
    cts_n = 1'b0;
    checks = 0;
    errors = 0;
    cyc = 0;
    fe_cnt = 0;
    ov_cnt = 0;
    mon_len = 8;
    test_reset();
    test_tx_pattern();
    test_tx_random();
    test_rx_pattern();
    test_rx_random();
    test_frame_err();
    test_overrun();
    test_cts();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
